// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte push handshake from the UART register block into the TX datapath
//
// Signals:
//   wr_valid_i  push request from the register block
//   wr_data_i   byte to push
//   wr_ready_o  TX FIFO can accept a byte
// Modports: master = register block side, slave = uart_tx side.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_ready_o;

  modport master (output wr_valid_i, output wr_data_i, input wr_ready_o);
  modport slave  (input wr_valid_i, input wr_data_i, output wr_ready_o);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmit datapath: TX FIFO plus 8N1 serialiser
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   wr              push handshake (uart_tx_if.slave)
//   divider_i       bit period minus one, in clk cycles (captured at each pop)
//   tx_en_i         transmit enable; gates pops only, a running frame always completes
//   txd_o           registered serial line, idle high
//   busy_o          frame in progress
//   fifo_level_o    entries held; fifo_empty_o / fifo_full_o derived from it
//   done_o          one-cycle pulse on the final cycle of the stop bit
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_if.slave                      wr,
  input  logic [DIV_WIDTH-1:0]          divider_i,
  input  logic                          tx_en_i,
  output logic                          txd_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          fifo_empty_o,
  output logic                          fifo_full_o,
  output logic                          done_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic                  push, pop;
  logic [DIV_WIDTH-1:0]  div_q, cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IW-1:0]         idx;
  logic                  bit_end;

  assign fifo_level_o  = level;
  assign fifo_empty_o  = (level == '0);
  assign fifo_full_o   = (level == LW'(FIFO_DEPTH));
  // Ready depends only on full, so a same-cycle pop never makes room for a push.
  assign wr.wr_ready_o = !fifo_full_o;
  assign push          = wr.wr_valid_i && wr.wr_ready_o;
  assign bit_end       = (cnt == '0);
  assign busy_o        = (state != IDLE);

  // FIFO storage has no reset; only the pointers and level are flushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr.wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en_i && !fifo_empty_o) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && idx == IDX_LAST) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) begin
          done_o = 1'b1;
          // Popping on the last stop cycle gives zero-gap back-to-back frames.
          if (tx_en_i && !fifo_empty_o) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit datapath: txd_o is loaded one edge ahead of the bit it carries, so the
  // start bit appears on the cycle right after the pop edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd_o <= 1'b1;
      cnt   <= '0;
      div_q <= '0;
      shreg <= '0;
      idx   <= '0;
    end else if (pop) begin
      shreg <= mem[rd_ptr];
      div_q <= divider_i;
      cnt   <= divider_i;
      txd_o <= 1'b0;
    end else if (state != IDLE) begin
      if (bit_end) begin
        cnt <= div_q;
        case (state)
          START: begin
            idx   <= '0;
            txd_o <= shreg[0];
          end
          DATA: begin
            if (idx == IDX_LAST) begin
              txd_o <= 1'b1;
            end else begin
              idx   <= idx + IW'(1);
              shreg <= shreg >> 1;
              txd_o <= shreg[1];
            end
          end
          default: txd_o <= 1'b1;
        endcase
      end else begin
        cnt <= cnt - DIV_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level reference model
module tb_uart_tx;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DVW   = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [DVW-1:0] divider;
  logic           tx_en;
  logic           txd, busy, empty, full, done;
  logic [2:0]     level;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  // Reference model: byte queue for the FIFO, and the expected line value for
  // every remaining cycle of the frame in flight (head = current cycle).
  logic [DW-1:0] fifo_q[$];
  logic          line_q[$];

  uart_tx_if #(.DATA_WIDTH(DW)) wr_if ();

  uart_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DVW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr_if),
    .divider_i    (divider),
    .tx_en_i      (tx_en),
    .txd_o        (txd),
    .busy_o       (busy),
    .fifo_level_o (level),
    .fifo_empty_o (empty),
    .fifo_full_o  (full),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic          accept, pop;
    logic [DW-1:0] b;
    logic [DW+1:0] frame;
    @(posedge clk);
    if (rst) begin
      fifo_q.delete();
      line_q.delete();
    end else begin
      accept = wr_if.wr_valid_i && (fifo_q.size() < DEPTH);
      pop    = tx_en && (fifo_q.size() > 0) && (line_q.size() <= 1);
      if (line_q.size() > 0) void'(line_q.pop_front());
      if (pop) begin
        b     = fifo_q.pop_front();
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < DW + 2; i++)
          for (int k = 0; k <= int'(divider); k++) line_q.push_back(frame[i]);
      end
      if (accept) fifo_q.push_back(wr_if.wr_data_i);
    end
    #1;
    chk("txd",   32'(txd),   32'((line_q.size() > 0) ? line_q[0] : 1'b1));
    chk("busy",  32'(busy),  32'(line_q.size() > 0));
    chk("done",  32'(done),  32'(line_q.size() == 1));
    chk("level", 32'(level), 32'(fifo_q.size()));
    chk("empty", 32'(empty), 32'(fifo_q.size() == 0));
    chk("full",  32'(full),  32'(fifo_q.size() == DEPTH));
    chk("ready", 32'(wr_if.wr_ready_o), 32'(fifo_q.size() != DEPTH));
    if (done) n_done++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [DW-1:0] b);
    wr_if.wr_valid_i = 1'b1;
    wr_if.wr_data_i  = b;
    step();
    wr_if.wr_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    divider = 16'd3;
    tx_en = 1'b0;
    wr_if.wr_valid_i = 1'b0;
    wr_if.wr_data_i  = '0;

    // Reset state
    run(2);
    rst = 1'b0;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(wr_if.wr_ready_o), 32'd1);

    // Single byte 0xA5, 4-cycle bits: line falls on the second edge after the push
    tx_en = 1'b1;
    n_done = 0;
    push(8'hA5);
    chk("single_latency_hi", 32'(txd), 32'd1);
    step();
    chk("single_latency_lo", 32'(txd), 32'd0);
    run(44);
    chk("single_done_count", 32'(n_done), 32'd1);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Back-to-back 0x00, 0xFF with 1-cycle bits
    divider = 16'd0;
    n_done = 0;
    push(8'h00);
    push(8'hFF);
    run(25);
    chk("b2b_done_count", 32'(n_done), 32'd2);

    // FIFO full: fifth byte dropped, then drained in order
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h11 + i));
    chk("full_level", 32'(level), 32'd4);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_ready", 32'(wr_if.wr_ready_o), 32'd0);
    tx_en = 1'b1;
    run(45);
    chk("full_drained", 32'(level), 32'd0);

    // Enable drop during the DATA bits of the first of two queued bytes
    divider = 16'd1;
    tx_en = 1'b0;
    push(8'h3C);
    push(8'hC3);
    tx_en = 1'b1;
    run(7);
    tx_en = 1'b0;
    run(30);
    chk("endrop_level", 32'(level), 32'd1);
    chk("endrop_txd", 32'(txd), 32'd1);
    tx_en = 1'b1;
    run(25);

    // Divider change mid-frame: only the following frame sees the new value
    divider = 16'd1;
    push(8'h96);
    push(8'h5A);
    run(6);
    divider = 16'd4;
    run(80);

    // Reset mid-frame with two bytes queued
    divider = 16'd2;
    push(8'h81);
    push(8'h42);
    push(8'h24);
    run(8);
    rst = 1'b1;
    step();
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    n_done = 0;
    run(40);
    chk("midrst_no_frame", 32'(n_done), 32'd0);

    // Randomised traffic, enable toggling, divider changes and occasional reset
    for (int c = 0; c < 1500; c++) begin
      wr_if.wr_valid_i = ($urandom_range(0, 9) < 2);
      wr_if.wr_data_i  = 8'($urandom);
      if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 49) == 0) divider = 16'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    wr_if.wr_valid_i = 1'b0;
    rst = 1'b0;
    tx_en = 1'b1;
    run(250);
    chk("final_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
